// File: rtl/fmrv32im_axils_timer.sv
// AXI4-Lite responder for the fmrv32im peripheral port: a 32-bit timer with a
// compare register, a sticky MATCH flag and a level interrupt.
module fmrv32im_axils_timer #(
    parameter int          ADDR_WIDTH    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [3:0]            S_AXI_AWCACHE,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [3:0]            S_AXI_ARCACHE,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  TIMER_IRQ
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:4] == '0;
    endfunction

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  bvalid_q, rvalid_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [31:0]           rdata_q;

    logic [1:0]            ctrl;
    logic [31:0]           count, compare;
    logic                  match;

    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_ctrl, wr_count, wr_compare, wr_status;
    logic                  match_set, match_clr;
    logic [31:0]           rd_data;
    logic [1:0]            rd_resp;
    logic                  unused;

    assign S_AXI_AWREADY = ~aw_held & ~bvalid_q;
    assign S_AXI_WREADY  = ~w_held & ~bvalid_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign TIMER_IRQ     = match & ctrl[1];

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A held half of the write takes precedence over the live bus value.
    assign wr_addr = aw_held ? awaddr_q : S_AXI_AWADDR;
    assign wr_data = w_held ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held ? wstrb_q : S_AXI_WSTRB;
    assign commit  = (aw_hs | aw_held) & (w_hs | w_held) & ~bvalid_q;
    assign wr_ok   = commit & is_mapped(wr_addr);

    assign wr_ctrl    = wr_ok & (wr_addr[3:2] == 2'd0);
    assign wr_count   = wr_ok & (wr_addr[3:2] == 2'd1) & (|wr_strb);
    assign wr_compare = wr_ok & (wr_addr[3:2] == 2'd2);
    assign wr_status  = wr_ok & (wr_addr[3:2] == 2'd3);

    assign match_set = ctrl[0] & (count == compare);
    assign match_clr = wr_status & wr_strb[0] & wr_data[0];

    assign unused = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT,
                      S_AXI_ARADDR[1:0], wr_addr[1:0]};

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (!is_mapped(S_AXI_ARADDR)) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (S_AXI_ARADDR[3:2])
                2'd0:    rd_data = {30'd0, ctrl};
                2'd1:    rd_data = count;
                2'd2:    rd_data = compare;
                default: rd_data = {31'd0, match};
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (bvalid_q && S_AXI_BREADY) begin
                    bvalid_q <= 1'b0;
                    bresp_q  <= RESP_OKAY;
                end
            end
        end
    end

    // Capture registers only matter while the matching held flag is set.
    always_ff @(posedge CLK) begin
        if (aw_hs) awaddr_q <= S_AXI_AWADDR;
        if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_resp;
            rdata_q  <= rd_data;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl    <= 2'd0;
            count   <= 32'd0;
            compare <= RESET_COMPARE;
            match   <= 1'b0;
        end else begin
            if (wr_ctrl && wr_strb[0]) ctrl <= wr_data[1:0];
            if (wr_count)        count <= merge_bytes(count, wr_data, wr_strb);
            else if (ctrl[0])    count <= count + 32'd1;
            if (wr_compare) compare <= merge_bytes(compare, wr_data, wr_strb);
            // A fresh match beats a same-cycle clear so no event is lost.
            if (match_set)      match <= 1'b1;
            else if (match_clr) match <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fmrv32im_axils_timer.sv
// Randomized scoreboard bench for fmrv32im_axils_timer with a register-level
// reference model of the timer block.
`timescale 1ns/1ps
module tb_fmrv32im_axils_timer;
    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] S_AXI_AWADDR = '0;
    logic [3:0]    S_AXI_AWCACHE = '0;
    logic [2:0]    S_AXI_AWPROT = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b0;
    logic [AW-1:0] S_AXI_ARADDR = '0;
    logic [3:0]    S_AXI_ARCACHE = '0;
    logic [2:0]    S_AXI_ARPROT = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b0;
    logic          TIMER_IRQ;

    always #5 CLK = ~CLK;

    fmrv32im_axils_timer #(.ADDR_WIDTH(AW), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .TIMER_IRQ(TIMER_IRQ)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the pending-response queues.
    logic [1:0]    m_ctrl;
    logic [31:0]   m_count, m_cmp;
    logic          m_match;
    logic          ev_wr = 1'b0, ev_rd = 1'b0;
    logic [AW-1:0] ev_waddr = '0, ev_raddr = '0;
    logic [31:0]   ev_wdata = '0;
    logic [3:0]    ev_wstrb = '0;
    logic [1:0]    bq[$];
    logic [33:0]   rq[$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic hits(input int idx);
        return ev_wr && (ev_waddr < 16) && (ev_waddr[3:2] == 2'(idx));
    endfunction

    function automatic logic [33:0] model_read(input logic [AW-1:0] a);
        if (a >= 16) return {2'b10, 32'h0};
        case (a[3:2])
            2'd0:    return {2'b00, 30'h0, m_ctrl};
            2'd1:    return {2'b00, m_count};
            2'd2:    return {2'b00, m_cmp};
            default: return {2'b00, 31'h0, m_match};
        endcase
    endfunction

    function automatic logic [1:0] next_ctrl();
        return (hits(0) && ev_wstrb[0]) ? ev_wdata[1:0] : m_ctrl;
    endfunction

    function automatic logic [31:0] next_count();
        if (hits(1) && ev_wstrb != 4'h0) return merge(m_count, ev_wdata, ev_wstrb);
        return m_ctrl[0] ? m_count + 32'd1 : m_count;
    endfunction

    function automatic logic [31:0] next_cmp();
        return hits(2) ? merge(m_cmp, ev_wdata, ev_wstrb) : m_cmp;
    endfunction

    function automatic logic next_match();
        if (m_ctrl[0] && m_count == m_cmp) return 1'b1;
        if (hits(3) && ev_wstrb[0] && ev_wdata[0]) return 1'b0;
        return m_match;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_ctrl  <= 2'd0;
            m_count <= 32'd0;
            m_cmp   <= 32'hFFFF_FFFF;
            m_match <= 1'b0;
            bq.delete();
            rq.delete();
        end else begin
            if (ev_rd) rq.push_back(model_read(ev_raddr));
            if (ev_wr) bq.push_back((ev_waddr < 16) ? 2'b00 : 2'b10);
            m_ctrl  <= next_ctrl();
            m_count <= next_count();
            m_cmp   <= next_cmp();
            m_match <= next_match();
        end
    end

    // Monitor: pops the scoreboard on every response handshake, tracks the IRQ.
    always begin
        @(negedge CLK);
        #1;
        if (!RST) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                chk("b_pending", bq.size() != 0, 1);
                if (bq.size() != 0) chk("bresp", S_AXI_BRESP, bq.pop_front());
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                chk("r_pending", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    logic [33:0] e;
                    e = rq.pop_front();
                    chk("rdata", S_AXI_RDATA, e[31:0]);
                    chk("rresp", S_AXI_RRESP, e[33:32]);
                end
            end
            chk("irq", TIMER_IRQ, m_match & m_ctrl[1]);
        end
    end

    task automatic finish_write(input int bdly);
        chk("bvalid", S_AXI_BVALID, 1);
        chk("awready_busy", S_AXI_AWREADY, 0);
        repeat (bdly) begin
            @(negedge CLK);
            chk("bvalid_hold", S_AXI_BVALID, 1);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge CLK);
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clr", S_AXI_BVALID, 0);
    endtask

    // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int gap, input int bdly,
                            input bit use_sync = 1'b0, input logic [31:0] sync_cnt = 32'h0);
        int k;
        k = (gap < 0) ? -gap : gap;
        @(negedge CLK);
        ev_waddr = a; ev_wdata = d; ev_wstrb = s;
        if (gap >= 0) begin
            S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
            chk("awready", S_AXI_AWREADY, 1);
        end
        if (gap <= 0) begin
            S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
            chk("wready", S_AXI_WREADY, 1);
        end
        if (gap != 0) begin
            @(negedge CLK);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (use_sync ? (m_count == sync_cnt) : (i >= k - 1)) break;
                chk("awready_held", S_AXI_AWREADY, gap < 0);
                chk("wready_held", S_AXI_WREADY, gap > 0);
                chk("bvalid_early", S_AXI_BVALID, 0);
                @(negedge CLK);
            end
            if (use_sync) chk("sync_reached", m_count, sync_cnt);
            if (gap > 0) begin
                S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
                chk("wready_late", S_AXI_WREADY, 1);
                chk("awready_held", S_AXI_AWREADY, 0);
            end else begin
                S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
                chk("awready_late", S_AXI_AWREADY, 1);
                chk("wready_held", S_AXI_WREADY, 0);
            end
        end
        ev_wr = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; ev_wr = 1'b0;
        finish_write(bdly);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdly);
        @(negedge CLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        chk("arready", S_AXI_ARREADY, 1);
        ev_raddr = a; ev_rd = 1'b1;
        @(negedge CLK);
        S_AXI_ARVALID = 1'b0; ev_rd = 1'b0;
        chk("rvalid", S_AXI_RVALID, 1);
        repeat (rdly) begin
            chk("arready_busy", S_AXI_ARREADY, 0);
            @(negedge CLK);
            chk("rvalid_hold", S_AXI_RVALID, 1);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge CLK);
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clr", S_AXI_RVALID, 0);
        chk("arready_back", S_AXI_ARREADY, 1);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel < 4) return AW'(sel * 4 + $urandom_range(0, 3));
        if (sel == 4) return AW'($urandom_range(16, 31));
        return AW'($urandom_range(32, 65535));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] target;
        repeat (3) @(negedge CLK);
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_bresp", S_AXI_BRESP, 0);
        chk("rst_rresp", S_AXI_RRESP, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_irq", TIMER_IRQ, 0);
        RST = 1'b0;
        for (int r = 0; r < 4; r++) do_read(AW'(r * 4), 0);

        // Enable and watch COUNT advance.
        do_write(16'h0000, 32'h3, 4'hF, 0, 0);
        do_read(16'h0004, 0);
        do_read(16'h0004, 1);

        // Address before data.
        do_write(16'h0008, 32'h0000_0010, 4'hF, 3, 0);
        do_read(16'h0008, 0);

        // Match and interrupt, then W1C.
        do_write(16'h0000, 32'h0, 4'hF, 0, 0);
        do_write(16'h0004, 32'h0, 4'hF, 0, 0);
        do_write(16'h0008, 32'h5, 4'hF, -2, 1);
        do_write(16'h0000, 32'h3, 4'hF, 0, 0);
        repeat (12) @(negedge CLK);
        chk("irq_match", TIMER_IRQ, 1);
        do_read(16'h000C, 0);
        do_write(16'h000C, 32'h1, 4'hF, 0, 0);
        chk("irq_cleared", TIMER_IRQ, 0);

        // Clear landing on the same edge as a fresh match.
        target = m_count + 32'd40;
        do_write(16'h0008, target, 4'hF, 0, 0);
        do_write(16'h000C, 32'h1, 4'hF, 1, 0, 1'b1, target);
        chk("match_beats_clear", TIMER_IRQ, 1);
        do_read(16'h000C, 0);

        // Byte strobes and a strobe-less write.
        do_write(16'h0008, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_write(16'h0008, 32'hAABB_CCDD, 4'b0101, 0, 0);
        do_read(16'h0008, 0);
        do_write(16'h0008, 32'h1234_5678, 4'h0, 0, 0);
        do_read(16'h0008, 0);

        // Unmapped access, with a long-held read response.
        do_write(16'h0010, 32'h1234_5678, 4'hF, 0, 0);
        do_read(16'h0010, 5);
        for (int r = 0; r < 4; r++) do_read(AW'(r * 4), 0);

        // Wrap of COUNT.
        do_write(16'h0000, 32'h0, 4'hF, 0, 0);
        do_write(16'h0004, 32'hFFFF_FFFF, 4'hF, 0, 0);
        fork
            do_write(16'h0000, 32'h1, 4'hF, 0, 0);
            begin @(negedge CLK); @(negedge CLK); do_read(16'h0004, 0); end
        join
        do_read(16'h0004, 0);

        // Randomized mix, sometimes with concurrent read and write.
        for (int it = 0; it < 80; it++) begin
            automatic logic [AW-1:0] wa = rnd_addr();
            automatic logic [AW-1:0] ra = rnd_addr();
            automatic logic [31:0]   wd = $urandom;
            automatic logic [3:0]    ws = 4'($urandom_range(0, 15));
            automatic int            gp = $urandom_range(0, 6) - 3;
            automatic int            bd = $urandom_range(0, 3);
            automatic int            rd = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: do_write(wa, wd, ws, gp, bd);
                1: do_read(ra, rd);
                default: fork
                    do_write(wa, wd, ws, gp, bd);
                    do_read(ra, rd);
                join
            endcase
        end

        // Reset while a write response is pending.
        do_write(16'h0000, 32'h3, 4'hF, 0, 0);
        @(negedge CLK);
        S_AXI_AWADDR = 16'h0008; S_AXI_WDATA = 32'h7; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        ev_waddr = 16'h0008; ev_wdata = 32'h7; ev_wstrb = 4'hF; ev_wr = 1'b1;
        @(negedge CLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; ev_wr = 1'b0;
        chk("bvalid_pre_rst", S_AXI_BVALID, 1);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_bvalid", S_AXI_BVALID, 0);
        chk("rst_mid_awready", S_AXI_AWREADY, 1);
        chk("rst_mid_wready", S_AXI_WREADY, 1);
        chk("rst_mid_irq", TIMER_IRQ, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int r = 0; r < 4; r++) do_read(AW'(r * 4), 0);

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
